// File: rtl/md_ctrl_pkg.sv
// Shared op encodings, default latencies and helpers for the HI/LO unit.
// MD_DIV_EN enables the DIV/DIVU path; without it those ops are reserved.
package md_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a multi-cycle latency
    function automatic logic md_is_arith(input logic [2:0] op);
`ifdef MD_DIV_EN
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

endpackage

// File: rtl/md_ctrl_mux.sv
// Generic 2:1 mux used for the HI/LO read-back path.
module md_ctrl_mux #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? SrcB : SrcA;

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller with HI/LO registers and stall.
// MD_DIV_EN: define to build the DIV/DIVU datapath.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             md_use,
    input  logic             rd_sel,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

`ifdef MD_DIV_EN
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
`else
    localparam int MAXC = MULT_CYCLES;
`endif
    localparam int CW = $clog2(MAXC + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    md_state_e        state;

    logic signed [2*WIDTH-1:0] sa_ext, sb_ext;
    logic [2*WIDTH-1:0]        prod_s, prod_u;

    assign sa_ext = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign sb_ext = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign prod_s = sa_ext * sb_ext;
    assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

`ifdef MD_DIV_EN
    logic [WIDTH-1:0] divs_q, divs_r, divu_q, divu_r;
    logic             b_zero, s_ovf;

    assign b_zero = (src_b == '0);
    assign s_ovf  = (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);

    // Guard the corner cases so the raw dividers never see them
    always_comb begin
        divs_q = '1;
        divs_r = src_a;
        divu_q = '1;
        divu_r = src_a;
        if (!b_zero) begin
            divu_q = src_a / src_b;
            divu_r = src_a % src_b;
            if (s_ovf) begin
                divs_q = src_a;
                divs_r = '0;
            end else begin
                divs_q = $signed(src_a) / $signed(src_b);
                divs_r = $signed(src_a) % $signed(src_b);
            end
        end
    end
`endif

    assign state = (cnt_q == '0) ? MD_IDLE : MD_RUN;

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        unique case (state)
            MD_IDLE: begin
                if (start) begin
                    unique case (op)
                        MD_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d = CW'(MULT_CYCLES);
                        end
                        MD_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d = CW'(MULT_CYCLES);
                        end
`ifdef MD_DIV_EN
                        MD_DIV: begin
                            pend_hi_d = divs_r;
                            pend_lo_d = divs_q;
                            cnt_d     = CW'(DIV_CYCLES);
                        end
                        MD_DIVU: begin
                            pend_hi_d = divu_r;
                            pend_lo_d = divu_q;
                            cnt_d     = CW'(DIV_CYCLES);
                        end
`endif
                        MD_MTHI: hi_d = src_a;
                        MD_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy  = (state == MD_RUN);
    assign stall = md_use & (busy | (start & md_is_arith(op)));
    assign hi    = hi_q;
    assign lo    = lo_q;

    md_ctrl_mux #(
        .WIDTH(WIDTH)
    ) u_rd_mux (
        .SrcA(lo_q),
        .SrcB(hi_q),
        .sel (rd_sel),
        .y   (rd_data)
    );

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multi-cycle multiply/divide controller for the pipelined MIPS core's EX stage. It accepts one HI/LO operation per start pulse, holds the result for a fixed latency, then commits it to the HI/LO registers. While busy, it raises a stall request for any HI/LO-using instruction in decode. It also drives the HI/LO read-back selection through a 2:1 mux instance.

## Interface
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, latency of MULT/MULTU in cycles (≥1)
- DIV_CYCLES, 10, latency of DIV/DIVU in cycles (≥1)

- clk  in  1  rising-edge clock; the block uses one clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  EX-stage HI/LO instruction valid, one-cycle pulse
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved
- src_a  in  WIDTH  rs operand
- src_b  in  WIDTH  rt operand
- md_use  in  1  the instruction in decode uses HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
- rd_sel  in  1  read select: 0 LO, 1 HI
- busy  out  1  operation in flight
- stall  out  1  decode stall request
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- rd_data  out  WIDTH  rd_sel ? hi : lo

## Operation
- States: IDLE, RUN. The state is encoded by a down-counter `cnt`: IDLE when cnt==0, RUN otherwise.
- In IDLE, when start=1:
  - MULT/MULTU/DIV/DIVU:
    - latch the result into pend_hi/pend_lo;
    - load cnt with MULT_CYCLES or DIV_CYCLES.
  - MTHI/MTLO: write src_a into hi or lo at that edge; cnt stays 0 (no busy).
  - Reserved op: ignored.
- Arithmetic:
  - MULT: signed 2·WIDTH product, {hi,lo} = product.
  - MULTU: unsigned 2·WIDTH product, {hi,lo} = product.
  - DIV (signed): lo = quotient, hi = remainder. Truncation toward zero; the remainder takes the sign of the dividend.
  - DIVU (unsigned): lo = quotient, hi = remainder.
  - Divide by zero: lo = all-ones, hi = src_a.
  - Signed DIV of 0x80000000 by -1: lo = 0x80000000, hi = 0.
- In RUN, cnt decrements every cycle. On the edge where cnt==1, pend_hi/pend_lo are copied into hi/lo and cnt becomes 0.
- busy = (cnt != 0).
- stall = md_use & (busy | (start & op is MULT/MULTU/DIV/DIVU)).
- start while busy: ignored entirely, including MTHI/MTLO. The pipeline prevents this through stall; the bench checks that it is ignored.
- rd_data is combinational from the current hi/lo. It does not forward pend values or a same-cycle MTHI/MTLO write.

## Timing
- Reset, asynchronous:
  - hi=0, lo=0, cnt=0, pend_*=0;
  - busy=0, stall=0 (given md_use=0), rd_data=0.
- Start accepted at edge E0: busy=1 from just after E0 until just after edge E0+N, where N is the op latency. busy is therefore high for exactly N cycles.
- New hi/lo values are visible in the first cycle with busy=0.
- A back-to-back start in the cycle busy drops is accepted normally: zero bubble.
- MTHI/MTLO: hi/lo is updated at the accepting edge (latency 1); busy never rises.
- rst_n asserted mid-RUN: the operation is discarded, hi/lo return to 0, and busy drops immediately (asynchronous).
- stall is combinational, so it asserts in the same cycle as start for a mult/div op.

## Configuration
- MD_DIV_EN defined:
  - DIV/DIVU are implemented as specified;
  - the divider logic is instantiated.
- MD_DIV_EN undefined:
  - DIV/DIVU are treated as reserved ops: ignored, no busy, hi/lo unchanged;
  - no divider logic is synthesised;
  - DIV_CYCLES is unused.

## Structure
- Shared package:
  - the op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO (3-bit localparams);
  - the default latencies.
- The sub-module is the existing 2:1 mux, instantiated with WIDTH for rd_data (SrcA=lo, SrcB=hi, sel=rd_sel).
- Counter, pend registers and arithmetic live in md_ctrl itself.

## Test plan
- MULT, src_a=0xFFFFFFFE (−2), src_b=3 -> busy high for 5 cycles. Then hi=0xFFFFFFFF, lo=0xFFFFFFFA; rd_sel=1 gives rd_data=0xFFFFFFFF.
- MULTU, src_a=0xFFFFFFFF, src_b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV, src_a=−7 (0xFFFFFFF9), src_b=2 -> busy for 10 cycles. Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU, src_b=0, src_a=0x1234 -> lo=0xFFFFFFFF, hi=0x00001234.
- md_use=1 throughout a MULT -> stall=1 from the start cycle through the last busy cycle, and 0 the cycle after.
- Second start issued while busy is ignored (hi/lo reflect only the first op). MTLO 0xABCD in IDLE gives lo=0xABCD after one edge with busy=0. rst_n pulsed at cycle 3 of a DIV clears busy, hi and lo immediately.
